// File: rtl/signed_digit_decomp_pipe_pkg.sv
// Shared defaults and derived constants for the signed-digit decomposer.
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 32
`endif
`ifndef MODULUS
`define MODULUS 132120577
`endif

package signed_digit_decomp_pipe_pkg;

    localparam int unsigned DEFAULT_DATA_W   = `DATA_SIZE_ARB;
    localparam int unsigned DEFAULT_Q        = `MODULUS;
    localparam int unsigned DEFAULT_BASE_LOG = 7;
    localparam int unsigned DEFAULT_DIGITS   = 4;

    function automatic int unsigned halfQ(input int unsigned q);
        return q >> 1;
    endfunction

    // A negative digit r - B is emitted as r + (Q - B).
    function automatic int unsigned liftConst(input int unsigned q, input int unsigned baseLog);
        return q - (32'd1 << baseLog);
    endfunction

    localparam int unsigned HALF_Q         = halfQ(DEFAULT_Q);
    localparam int unsigned LIFT_Q_MINUS_B = liftConst(DEFAULT_Q, DEFAULT_BASE_LOG);

endpackage

// File: rtl/signed_digit_decomp_pipe_digit_stage.sv
// One balanced-digit extract/carry/lift stage with its elastic pipeline register.
module sdd_digit_stage
    import signed_digit_decomp_pipe_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned Q        = DEFAULT_Q,
    parameter int unsigned BASE_LOG = DEFAULT_BASE_LOG,
    parameter int unsigned DIGITS   = DEFAULT_DIGITS,
    parameter int unsigned IDX      = 0,
    parameter bit          LAST     = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       inValid,
    output logic                       inReady,
    input  logic signed [DATA_W:0]     inRem,
    input  logic [DIGITS*DATA_W-1:0]   inDigits,
    input  logic                       inLast,
    input  logic                       inErr,
    output logic                       outValid,
    input  logic                       outReady,
    output logic signed [DATA_W:0]     outRem,
    output logic [DIGITS*DATA_W-1:0]   outDigits,
    output logic                       outLast,
    output logic                       outErr
);

    localparam logic [DATA_W-1:0] LIFT = DATA_W'(liftConst(Q, BASE_LOG));

    logic [BASE_LOG-1:0]       r;
    logic                      neg;
    logic [DATA_W-1:0]         digit;
    logic signed [DATA_W:0]    shifted;
    logic signed [DATA_W:0]    nextRem;
    logic [DIGITS*DATA_W-1:0]  nextDigits;

    logic                      validQ;
    logic signed [DATA_W:0]    remQ;
    logic [DIGITS*DATA_W-1:0]  digitsQ;
    logic                      lastQ;
    logic                      errQ;

    // The top bit of r is both the carry and the sign of the final digit.
    always_comb begin
        r       = inRem[BASE_LOG-1:0];
        neg     = r[BASE_LOG-1];
        digit   = {{(DATA_W-BASE_LOG){1'b0}}, r};
        if (neg) begin
            digit = digit + LIFT;
        end
        shifted = inRem >>> BASE_LOG;
        nextRem = LAST ? '0 : shifted + $signed({{DATA_W{1'b0}}, neg});
        nextDigits = inDigits;
        nextDigits[IDX*DATA_W +: DATA_W] = digit;
    end

    assign inReady = !validQ | outReady;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validQ  <= 1'b0;
            remQ    <= '0;
            digitsQ <= '0;
            lastQ   <= 1'b0;
            errQ    <= 1'b0;
        end else if (inReady) begin
            validQ <= inValid;
            if (inValid) begin
                remQ    <= nextRem;
                digitsQ <= nextDigits;
                lastQ   <= inLast;
                errQ    <= inErr;
            end
        end
    end

    assign outValid  = validQ;
    assign outRem    = remQ;
    assign outDigits = digitsQ;
    assign outLast   = lastQ;
    assign outErr    = errQ;

endmodule

// File: rtl/signed_digit_decomp_pipe.sv
// Elastic signed-digit (gadget) decomposer: centre stage plus DIGITS digit stages.
// Optional input range check enabled by defining DECOMP_RANGE_CHECK_EN.
module signed_digit_decomp_pipe
    import signed_digit_decomp_pipe_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned Q        = DEFAULT_Q,
    parameter int unsigned BASE_LOG = DEFAULT_BASE_LOG,
    parameter int unsigned DIGITS   = DEFAULT_DIGITS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIGITS*DATA_W-1:0]  out_digits,
    output logic                      out_last,
    output logic                      out_err
);

    localparam logic [DATA_W-1:0] Q_V          = DATA_W'(Q);
    localparam logic [DATA_W-1:0] CENTRE_LIMIT = DATA_W'(halfQ(Q));

    if (DIGITS * BASE_LOG < $clog2(Q) + 1) begin : gErrDigits
        $error("DIGITS*BASE_LOG too small for Q");
    end
    if (BASE_LOG < 2) begin : gErrBase
        $error("BASE_LOG must be at least 2");
    end
    if ((64'(Q) >> DATA_W) != 64'd0) begin : gErrWidth
        $error("Q must be below 2**DATA_W");
    end

    logic [DIGITS+1:0]          stageReady;
    logic [DIGITS:0]            stageValid;
    logic signed [DATA_W:0]     remChain [DIGITS+1];
    logic [DIGITS*DATA_W-1:0]   digChain [DIGITS+1];
    logic [DIGITS:0]            lastChain;
    logic [DIGITS:0]            errChain;

    logic signed [DATA_W:0]     centred;
    logic                       rangeErr;
    logic                       s0Valid;
    logic signed [DATA_W:0]     s0Rem;
    logic                       s0Last;
    logic                       s0Err;
    logic                       unusedRem;

    always_comb begin
        if (in_data < CENTRE_LIMIT) begin
            centred = $signed({1'b0, in_data});
        end else begin
            centred = $signed({1'b0, in_data} - {1'b0, Q_V});
        end
    end

`ifdef DECOMP_RANGE_CHECK_EN
    assign rangeErr = (in_data >= Q_V);
`else
    assign rangeErr = 1'b0;
`endif

    assign stageReady[0]        = !s0Valid | stageReady[1];
    assign stageReady[DIGITS+1] = out_ready;
    assign in_ready             = stageReady[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0Valid <= 1'b0;
            s0Rem   <= '0;
            s0Last  <= 1'b0;
            s0Err   <= 1'b0;
        end else if (stageReady[0]) begin
            s0Valid <= in_valid;
            if (in_valid) begin
                s0Rem  <= centred;
                s0Last <= in_last;
                s0Err  <= rangeErr;
            end
        end
    end

    assign stageValid[0] = s0Valid;
    assign remChain[0]   = s0Rem;
    assign digChain[0]   = '0;
    assign lastChain[0]  = s0Last;
    assign errChain[0]   = s0Err;

    for (genvar k = 1; k <= DIGITS; k++) begin : gStage
        sdd_digit_stage #(
            .DATA_W   (DATA_W),
            .Q        (Q),
            .BASE_LOG (BASE_LOG),
            .DIGITS   (DIGITS),
            .IDX      (k - 1),
            .LAST     (k == DIGITS)
        ) uStage (
            .clk       (clk),
            .rst       (rst),
            .inValid   (stageValid[k-1]),
            .inReady   (stageReady[k]),
            .inRem     (remChain[k-1]),
            .inDigits  (digChain[k-1]),
            .inLast    (lastChain[k-1]),
            .inErr     (errChain[k-1]),
            .outValid  (stageValid[k]),
            .outReady  (stageReady[k+1]),
            .outRem    (remChain[k]),
            .outDigits (digChain[k]),
            .outLast   (lastChain[k]),
            .outErr    (errChain[k])
        );
    end

    assign unusedRem  = ^remChain[DIGITS];
    assign out_valid  = stageValid[DIGITS];
    assign out_digits = digChain[DIGITS];
    assign out_last   = lastChain[DIGITS];
    assign out_err    = errChain[DIGITS];

endmodule
